vga_timing_gen: RTL and testbench

//  Pixel-timing generator directly upstream of the VGA output driver.

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel timing: pixel-enable divider, x/y coordinates, line/frame strobes, frame counter.
// Define VGA_TIMING_PATTERN_EN to add an 8-bar colour test pattern on red/green/blue.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_TOTAL  = 1056,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_TOTAL  = 628,
  parameter int unsigned CLK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] xCoord,
  output logic [10:0] yCoord,
  output logic        pix_en,
  output logic        line_start,
  output logic        frame_start,
  output logic        active,
  output logic [15:0] frame_count
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
`endif
);

  localparam int unsigned CW    = 11;
  localparam int unsigned FC_W  = 16;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0]    V_ACT    = CW'(V_ACTIVE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             h_wrap_c;
  logic             v_wrap_c;

  assign pix_en   = !rst && (div_cnt == DIV_LAST);
  assign h_wrap_c = (xCoord == H_LAST);
  assign v_wrap_c = (yCoord == V_LAST);
  assign active   = (xCoord < H_ACT) && (yCoord < V_ACT);

  // Clock divider producing one pixel tick every CLK_DIV clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Coordinate counters; strobes coincide with the wrapped coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      xCoord      <= '0;
      yCoord      <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (h_wrap_c) begin
          xCoord     <= '0;
          line_start <= 1'b1;
          if (v_wrap_c) begin
            yCoord      <= '0;
            frame_count <= frame_count + FC_W'(1);
            frame_start <= 1'b1;
          end else begin
            yCoord <= yCoord + CW'(1);
          end
        end else begin
          xCoord <= xCoord + CW'(1);
        end
      end
    end
  end

`ifdef VGA_TIMING_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_c;
  logic [23:0] rgb_c;

  // Bar index via comparator chain against bar boundaries
  always_comb begin
    bar_c = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (xCoord < CW'((i + 1) * BAR_W)) begin
        bar_c = 3'(i);
      end
    end
  end

  always_comb begin
    rgb_c = 24'h000000;
    if (active) begin
      case (bar_c)
        3'd0:    rgb_c = 24'hFFFFFF;
        3'd1:    rgb_c = 24'hFFFF00;
        3'd2:    rgb_c = 24'h00FFFF;
        3'd3:    rgb_c = 24'h00FF00;
        3'd4:    rgb_c = 24'hFF00FF;
        3'd5:    rgb_c = 24'hFF0000;
        3'd6:    rgb_c = 24'h0000FF;
        default: rgb_c = 24'h000000;
      endcase
    end
  end

  assign red   = rgb_c[23:16];
  assign green = rgb_c[15:8];
  assign blue  = rgb_c[7:0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries checked every cycle against an arithmetic timing model.
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int P_HA [NI] = '{800, 8, 16};
  localparam int P_HT [NI] = '{1056, 12, 20};
  localparam int P_VA [NI] = '{600, 3, 2};
  localparam int P_VT [NI] = '{628, 5, 3};
  localparam int P_DIV[NI] = '{1, 1, 3};
  localparam logic [23:0] COLOURS[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] xc[NI];
  logic [10:0] yc[NI];
  logic        pe[NI];
  logic        ls[NI];
  logic        fs[NI];
  logic        act[NI];
  logic [15:0] fc[NI];
`ifdef VGA_TIMING_PATTERN_EN
  logic [7:0]  rd[NI];
  logic [7:0]  gr[NI];
  logic [7:0]  bl[NI];
`endif

  int  errors = 0;
  int  checks = 0;
  int  n = 0;
  bit  valid = 1'b0;
  bit  early = 1'b1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE(P_HA[g]),
      .H_TOTAL (P_HT[g]),
      .V_ACTIVE(P_VA[g]),
      .V_TOTAL (P_VT[g]),
      .CLK_DIV (P_DIV[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .xCoord     (xc[g]),
      .yCoord     (yc[g]),
      .pix_en     (pe[g]),
      .line_start (ls[g]),
      .frame_start(fs[g]),
      .active     (act[g]),
      .frame_count(fc[g])
`ifdef VGA_TIMING_PATTERN_EN
      ,
      .red        (rd[g]),
      .green      (gr[g]),
      .blue       (bl[g])
`endif
    );
  end

  function automatic logic [23:0] dut_rgb(int g);
`ifdef VGA_TIMING_PATTERN_EN
    return {rd[g], gr[g], bl[g]};
`else
    return 24'h0;
`endif
  endfunction

  function automatic logic [65:0] dut_vec(int g);
    return {dut_rgb(g), fc[g], xc[g], yc[g], pe[g], ls[g], fs[g], act[g]};
  endfunction

  // Outputs derived from the number of non-reset edges since the last reset edge
  function automatic logic [65:0] model_vec(int g, int edges, bit r);
    int p, x, y, f, bw;
    bit tick_pe, ls_e, fs_e, act_e;
    logic [23:0] rgb;
    p       = edges / P_DIV[g];
    x       = p % P_HT[g];
    y       = (p / P_HT[g]) % P_VT[g];
    f       = (p / (P_HT[g] * P_VT[g])) % 65536;
    tick_pe = !r && (edges % P_DIV[g] == P_DIV[g] - 1);
    ls_e    = (edges > 0) && (edges % P_DIV[g] == 0) && (x == 0);
    fs_e    = ls_e && (y == 0);
    act_e   = (x < P_HA[g]) && (y < P_VA[g]);
    rgb     = 24'h0;
`ifdef VGA_TIMING_PATTERN_EN
    bw = P_HA[g] / 8;
    if (act_e) rgb = COLOURS[x / bw];
`else
    bw = 0;
`endif
    return {rgb, 16'(f), 11'(x), 11'(y), tick_pe, ls_e, fs_e, act_e} | 66'(bw & 0);
  endfunction

  task automatic chk(input string name, input logic [65:0] a, input logic [65:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s n=%0d actual=%h expected=%h", name, n, a, e);
    end
  endtask

  task automatic pins();
    if (!early) return;
    if (n == 0 && !rst) begin
      chk("rst_d0_zero", 66'({xc[0], yc[0], fc[0], ls[0], fs[0]}), 66'(0));
      chk("rst_d0_act_pe", 66'({act[0], pe[0]}), 66'(2'b11));
      chk("rst_d2_pe", 66'(pe[2]), 66'(0));
    end
    if (n == 1055) chk("d0_x1055", 66'({xc[0], yc[0], ls[0]}), 66'({11'd1055, 11'd0, 1'b0}));
    if (n == 1056) chk("d0_line1", 66'({xc[0], yc[0], ls[0], fs[0]}), 66'({11'd0, 11'd1, 1'b1, 1'b0}));
    if (n == 1057) chk("d0_ls_1clk", 66'({xc[0], ls[0]}), 66'({11'd1, 1'b0}));
    if (n == 10)   chk("d2_div_n10", 66'({xc[2], pe[2]}), 66'({11'd3, 1'b0}));
    if (n == 11)   chk("d2_div_n11", 66'({xc[2], pe[2]}), 66'({11'd3, 1'b1}));
    if (n == 60)   chk("d1_frame1", 66'({xc[1], yc[1], ls[1], fs[1], fc[1]}),
                       66'({11'd0, 11'd0, 1'b1, 1'b1, 16'd1}));
    if (n == 61)   chk("d1_fs_1clk", 66'({ls[1], fs[1], fc[1]}), 66'({1'b0, 1'b0, 16'd1}));
    if (n == 11360) chk("d0_x800_inactive", 66'({xc[0], yc[0], act[0]}), 66'({11'd800, 11'd10, 1'b0}));
`ifdef VGA_TIMING_PATTERN_EN
    if (n == 10560) chk("pat_x0",   66'(dut_rgb(0)), 66'(24'hFFFFFF));
    if (n == 10710) chk("pat_x150", 66'(dut_rgb(0)), 66'(24'hFFFF00));
    if (n == 11359) chk("pat_x799", 66'(dut_rgb(0)), 66'(24'h000000));
    if (n == 11360) chk("pat_x800", 66'(dut_rgb(0)), 66'(24'h000000));
`endif
  endtask

  // One clock: update model on the edge, drive rst after it, compare on the falling edge
  task automatic cycle(input bit r);
    @(posedge clk);
    if (rst) begin
      n     = 0;
      valid = 1'b1;
    end else begin
      n++;
    end
    #3 rst = r;
    @(negedge clk);
    if (valid) begin
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("model_d%0d", g), dut_vec(g), model_vec(g, n, rst));
      end
      pins();
    end
  endtask

  initial begin
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    for (int i = 0; i < 12000; i++) cycle(1'b0);

    // Single-cycle reset in mid-frame
    early = 1'b0;
    chk("d1_fc_nonzero_pre", 66'(fc[1] != 16'd0), 66'(1));
    cycle(1'b1);
    cycle(1'b0);
    chk("midrst_d1", 66'({xc[1], yc[1], fc[1], ls[1], fs[1]}), 66'(0));
    chk("midrst_d0", 66'({xc[0], yc[0], fc[0], ls[0], fs[0]}), 66'(0));
    cycle(1'b0);
    chk("midrst_d0_x1", 66'({xc[0], yc[0]}), 66'({11'd1, 11'd0}));

    for (int i = 0; i < 20000; i++) cycle($urandom_range(0, 499) == 0);
    cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
